apb_mem_completer: RTL and testbench

- APB completer backed by a flop-based word memory with runtime-programmable wait states and error response.
- Serves as the target endpoint for the DMA APB master in block-level and subsystem benches.
- Also serves as a small scratchpad on the peripheral bus.
- Accepts both standard setup/access sequencing and streaming masters that raise psel and penable together.

---
 rtl/apb_mem_completer.sv | 128 ++++++++++++
 tb/tb_apb_mem_completer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_completer.sv
// APB completer backed by a flop-based word memory.
// Programmable wait states, error response, and support for streaming (psel+penable together) masters.
module apb_mem_completer #(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          NumWords  = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [DataWidth-1:0]   pwdata_i,
    input  logic [DataWidth/8-1:0] pstrb_i,
    output logic [DataWidth-1:0]   prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    input  logic [3:0]             wait_cycles_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ByteShift = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] LowMask = AddrWidth'((1 << ByteShift) - 1);
    localparam logic [AddrWidth-1:0] DepthA  = AddrWidth'(NumWords);

    typedef enum logic {
        Idle,
        Access
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]   strb_q, strb_d;
    logic [DataWidth-1:0]   mem_q [NumWords];
    logic [DataWidth-1:0]   mem_d [NumWords];

    logic [AddrWidth-1:0]   off;
    logic [AddrWidth-1:0]   word;
    logic [IdxWidth-1:0]    idx;
    logic                   addr_err;

    // penable is irrelevant: a selected Idle completer always starts a transfer.
    logic unused_penable;
    assign unused_penable = penable_i;

    always_comb begin
        off      = addr_q - BaseAddr;
        word     = off >> ByteShift;
        idx      = word[IdxWidth-1:0];
        addr_err = (addr_q < BaseAddr) || (word >= DepthA) || ((off & LowMask) != '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        mem_d     = mem_q;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;

        case (state_q)
            Idle: begin
                if (psel_i) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    strb_d  = pstrb_i;
                    cnt_d   = wait_cycles_i;
                    state_d = Access;
                end
            end
            Access: begin
                if (!psel_i) begin
                    state_d = Idle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    pready_o  = 1'b1;
                    pslverr_o = addr_err;
                    state_d   = Idle;
                    if (!addr_err) begin
                        if (write_q) begin
                            for (int unsigned b = 0; b < StrbWidth; b++) begin
                                if (strb_q[b]) begin
                                    mem_d[idx][b*8 +: 8] = wdata_q[b*8 +: 8];
                                end
                            end
                        end else begin
                            prdata_o = mem_q[idx];
                        end
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Directed bench for apb_mem_completer: vector table plus hand-written
// wait-state, streaming, abort and reset sequences.
module tb_apb_mem_completer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  wait_cycles = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [64];

    apb_mem_completer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pstrb_i      (pstrb),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .wait_cycles_i(wait_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  w;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transfer with a setup cycle; paddr/pwdata are scrambled during Access.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] w, input bit zero_w,
                        output logic [31:0] rdata, output logic err, output int lat);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; wait_cycles = w;
        lat = 0; rdata = 32'hXXXX_XXXX; err = 1'bx;
        @(negedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            paddr = 32'hFFFF_FFF1;
            pwdata = 32'h5A5A_5A5A;
            if (zero_w) wait_cycles = 4'd0;
            @(negedge clk);
            if (pready) begin
                lat = i; rdata = prdata; err = pslverr;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[addr[7:2]][b*8 +: 8] = data[b*8 +: 8];
    endtask

    task automatic readback_all(input string name);
        logic [31:0] rd;
        logic        er;
        int          lt;
        for (int i = 0; i < 64; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, 4'd0, 1'b0, rd, er, lt);
            chk(name, rd, model[i]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic [31:0] sd [4];

        for (int i = 0; i < 64; i++) model[i] = '0;
        sd[0] = 32'h0101_A0A0; sd[1] = 32'h0202_B1B1;
        sd[2] = 32'h0303_C2C2; sd[3] = 32'h0404_D3D3;

        //           wr    addr        wdata          strb  w     exp_rd         err
        vecs[0]  = '{1'b1, 32'h08,  32'hDEADBEEF, 4'hF, 4'd0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h08,  32'h0,        4'h0, 4'd0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h00,  32'h11223344, 4'h5, 4'd0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h00,  32'h0,        4'h0, 4'd0, 32'h00220044, 1'b0};
        vecs[4]  = '{1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 4'd0, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h02,  32'hFFFFFFFF, 4'hF, 4'd0, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h100, 32'h0,        4'h0, 4'd0, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h08,  32'h0,        4'h0, 4'd2, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 32'h04,  32'hFFFFFFFF, 4'h0, 4'd0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h04,  32'h0,        4'h0, 4'd1, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'hFC,  32'hA5A5A5A5, 4'hF, 4'd0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'hFC,  32'h0,        4'h0, 4'd0, 32'hA5A5A5A5, 1'b0};
        vecs[12] = '{1'b1, 32'h00,  32'hAABBCCDD, 4'hA, 4'd0, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h00,  32'h0,        4'h0, 4'd0, 32'hAA22CC44, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_pready", {31'b0, pready}, 32'h0);
        chk("reset_pslverr", {31'b0, pslverr}, 32'h0);
        chk("reset_prdata", prdata, 32'h0);

        for (int v = 0; v < 14; v++) begin
            xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].w, 1'b0, rd, er, lt);
            chk($sformatf("vec%0d_latency", v), 32'(lt), 32'(vecs[v].w) + 32'd1);
            chk($sformatf("vec%0d_pslverr", v), {31'b0, er}, {31'b0, vecs[v].exp_err});
            if (!vecs[v].wr || vecs[v].exp_err)
                chk($sformatf("vec%0d_prdata", v), rd, vecs[v].exp_rd);
            if (vecs[v].wr && !vecs[v].exp_err)
                model_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb);
        end

        readback_all("readback_after_errors");

        // W=3 sampled at setup; later changes to wait_cycles_i have no effect.
        xfer(1'b1, 32'h20, 32'h7777_8888, 4'hF, 4'd3, 1'b1, rd, er, lt);
        chk("w3_latency", 32'(lt), 32'd4);
        model_write(32'h20, 32'h7777_8888, 4'hF);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, lt);
        chk("w3_readback", rd, 32'h7777_8888);

        // Streaming master: psel and penable held high for four writes.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; pstrb = 4'hF; wait_cycles = 4'd0;
        for (int c = 0; c < 8; c++) begin
            if ((c % 2) == 0) begin
                paddr = 32'((c / 2) * 4);
                pwdata = sd[c / 2];
            end
            @(negedge clk);
            chk($sformatf("stream_pready_c%0d", c), {31'b0, pready}, ((c % 2) == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            model_write(32'(k * 4), sd[k], 4'hF);
            xfer(1'b0, 32'(k * 4), 32'h0, 4'h0, 4'd0, 1'b0, rd, er, lt);
            chk($sformatf("stream_readback%0d", k), rd, sd[k]);
        end

        // Abort: psel dropped during a W=5 access.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h1234_5678; pstrb = 4'hF; wait_cycles = 4'd5;
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            penable = (c < 2);
            psel = (c < 2);
            @(negedge clk);
            chk($sformatf("abort_pready_c%0d", c), {31'b0, pready}, 32'h0);
        end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, lt);
        chk("abort_no_write", rd, model[4]);

        // Reset during a read's pready cycle forces the outputs low immediately.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08; wait_cycles = 4'd0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("pre_reset_pready", {31'b0, pready}, 32'h1);
        chk("pre_reset_prdata", prdata, model[2]);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_pready", {31'b0, pready}, 32'h0);
        chk("async_reset_prdata", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 64; i++) model[i] = '0;

        // Reset in the middle of a W=5 write wait.
        xfer(1'b1, 32'h18, 32'h9999_0000, 4'hF, 4'd0, 1'b0, rd, er, lt);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1C;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF; wait_cycles = 4'd5;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            @(negedge clk);
            chk($sformatf("midwait_pready_c%0d", c), {31'b0, pready}, 32'h0);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midwait_reset_pslverr", {31'b0, pslverr}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        readback_all("readback_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
